// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared types and segment constants for the HH:MM scan display
package clock_disp_pkg;

   typedef logic [1:0] slot_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   localparam logic [3:0] ENC_BLANK = 4'd10;
   localparam logic [3:0] ENC_DASH  = 4'd11;

   // Segment pattern for a decimal digit; bit 0 = a .. bit 6 = g
   function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/clock_disp_scan_if.sv
// rtl/clock_disp_scan_if.sv - time-of-day bus in, multiplexed 7-segment pins out
interface clock_disp_scan_if;
   logic       ena;
   logic [3:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       am_pm;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] dig_en;

   modport master (
      output ena, hours, minutes, seconds, am_pm,
      input  seg, dp, dig_en
   );

   modport slave (
      input  ena, hours, minutes, seconds, am_pm,
      output seg, dp, dig_en
   );
endinterface

// File: rtl/seg7_enc.sv
// rtl/seg7_enc.sv - combinational digit/blank/dash code to 7-segment pattern
module seg7_enc
   import clock_disp_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (code_i == ENC_DASH) begin
         seg_o = SEG_DASH;
      end else begin
         seg_o = seg_of_digit(code_i);
      end
   end

endmodule

// File: rtl/clock_disp_scan.sv
// rtl/clock_disp_scan.sv - 4-digit HH:MM scan driver; LEADING_BLANK_EN blanks a zero hour-tens digit
module clock_disp_scan
   import clock_disp_pkg::*;
#(
   parameter int SCAN_DIV  = 10000,
   parameter int BLANK_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   clock_disp_scan_if.slave  bus_io
);

   localparam int            CW        = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

   logic [CW-1:0] cnt_q, cnt_d;
   slot_t         slot_q, slot_d;
   logic          snap;

   logic [3:0]    hr_q;
   logic [5:0]    min_q;
   logic          sec0_q;
   logic          pm_q;

   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    dig_en_q, dig_en_d;

   logic          valid;
   logic          hr_tens;
   logic [3:0]    hr_units;
   logic [2:0]    min_tens;
   logic [5:0]    min_base;
   logic [3:0]    min_units;
   logic [3:0]    code;
   logic          dp_sel;
   logic [6:0]    enc_seg;

   // A frozen scan (ena low) also suppresses the 3->0 wrap and its snapshot
   always_comb begin
      cnt_d  = cnt_q;
      slot_d = slot_q;
      snap   = 1'b0;
      if (bus_io.ena) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
            snap   = (slot_q == 2'd3);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         slot_q <= 2'd0;
         hr_q   <= 4'd12;
         min_q  <= 6'd0;
         sec0_q <= 1'b0;
         pm_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         slot_q <= slot_d;
         if (snap) begin
            hr_q   <= bus_io.hours;
            min_q  <= bus_io.minutes;
            sec0_q <= bus_io.seconds[0];
            pm_q   <= bus_io.am_pm;
         end
      end
   end

   assign valid    = (hr_q != 4'd0) && (hr_q <= 4'd12) && (min_q <= 6'd59);
   assign hr_tens  = (hr_q >= 4'd10);
   assign hr_units = hr_tens ? (hr_q - 4'd10) : hr_q;

   always_comb begin
      min_tens = 3'd0;
      min_base = 6'd0;
      if (min_q >= 6'd50) begin
         min_tens = 3'd5;
         min_base = 6'd50;
      end else if (min_q >= 6'd40) begin
         min_tens = 3'd4;
         min_base = 6'd40;
      end else if (min_q >= 6'd30) begin
         min_tens = 3'd3;
         min_base = 6'd30;
      end else if (min_q >= 6'd20) begin
         min_tens = 3'd2;
         min_base = 6'd20;
      end else if (min_q >= 6'd10) begin
         min_tens = 3'd1;
         min_base = 6'd10;
      end
   end

   assign min_units = 4'(min_q - min_base);

   always_comb begin
      code   = ENC_DASH;
      dp_sel = 1'b0;
      if (valid) begin
         case (slot_q)
            2'd0: begin
               code   = min_units;
               dp_sel = pm_q;
            end
            2'd1: code = {1'b0, min_tens};
            2'd2: begin
               code   = hr_units;
               dp_sel = ~sec0_q;
            end
            default: begin
               code = {3'b000, hr_tens};
`ifdef LEADING_BLANK_EN
               if (!hr_tens) begin
                  code = ENC_BLANK;
               end
`endif
            end
         endcase
      end
   end

   seg7_enc u_enc (
      .code_i (code),
      .seg_o  (enc_seg)
   );

   // Outputs reflect the pre-advance (slot, cnt) state, one cycle late
   always_comb begin
      seg_d    = 7'h00;
      dp_d     = 1'b0;
      dig_en_d = 4'h0;
      if (bus_io.ena) begin
         seg_d = enc_seg;
         dp_d  = dp_sel;
         if (cnt_q >= CNT_BLANK) begin
            dig_en_d = 4'(4'b0001 << slot_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q    <= 7'h00;
         dp_q     <= 1'b0;
         dig_en_q <= 4'h0;
      end else begin
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         dig_en_q <= dig_en_d;
      end
   end

   assign bus_io.seg    = seg_q;
   assign bus_io.dp     = dp_q;
   assign bus_io.dig_en = dig_en_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// tb/tb_clock_disp_scan.sv - self-checking bench for clock_disp_scan (SCAN_DIV=8, BLANK_CYC=2)
module tb_clock_disp_scan;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   clock_disp_scan_if bus ();

   clock_disp_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

`ifdef LEADING_BLANK_EN
   localparam logic [6:0] HT0 = 7'h00;
`else
   localparam logic [6:0] HT0 = 7'h3F;
`endif
   localparam logic [27:0] DASHES = {4{7'h40}};

   logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   typedef struct {
      int          h;
      int          m;
      int          s;
      int          ap;
      logic [27:0] segs;
      logic [3:0]  dps;
   } vec_t;

   vec_t tbl [8];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   function automatic void timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for digit enable", name);
   endfunction

   // Reference: straight decimal arithmetic on the time fields
   function automatic void model(input int h, input int m, input int s, input int ap,
                                 output logic [27:0] segs, output logic [3:0] dps);
      if (h < 1 || h > 12 || m > 59) begin
         segs = DASHES;
         dps  = 4'b0000;
      end else begin
         segs = {(h >= 10) ? lut[1] : HT0, lut[h % 10], lut[m / 10], lut[m % 10]};
         dps  = {1'b0, (s % 2) == 0, 1'b0, ap != 0};
      end
   endfunction

   task automatic set_time(input int h, input int m, input int s, input int ap);
      bus.hours   = 4'(h);
      bus.minutes = 6'(m);
      bus.seconds = 6'(s);
      bus.am_pm   = 1'(ap);
   endtask

   task automatic wait_dig(input logic [3:0] want, input string name);
      int n = 0;
      while (bus.dig_en !== want && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.dig_en !== want) timeout(name);
   endtask

   // Skips 'skip' frame starts, then records one whole frame slot 0..3
   task automatic capture(input int skip, output logic [27:0] segs, output logic [3:0] dps);
      logic [3:0] prev;
      int n = 0;
      int seen = 0;
      segs = '0;
      dps  = '0;
      prev = bus.dig_en;
      while (seen <= skip && n < 400) begin
         @(negedge clk);
         n++;
         if (bus.dig_en == 4'b0001 && prev != 4'b0001) seen++;
         prev = bus.dig_en;
      end
      if (seen <= skip) begin
         timeout("frame_start");
         return;
      end
      segs[6:0] = bus.seg;
      dps[0]    = bus.dp;
      for (int k = 1; k < 4; k++) begin
         wait_dig(4'(1 << k), "frame_slot");
         segs[k*7 +: 7] = bus.seg;
         dps[k]         = bus.dp;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [27:0] segs, esegs;
      logic [3:0]  dps, edps;
      int          cnt_on [4];
      int          multi;
      int          n;

      tbl[0] = '{12,  0,  0, 0, {7'h06, 7'h5B, 7'h3F, 7'h3F}, 4'b0100};
      tbl[1] = '{ 9, 45,  7, 1, {HT0,   7'h6F, 7'h66, 7'h6D}, 4'b0001};
      tbl[2] = '{ 0, 45,  7, 1, DASHES,                       4'b0000};
      tbl[3] = '{ 9, 60,  6, 0, DASHES,                       4'b0000};
      tbl[4] = '{ 3,  7,  0, 0, {HT0,   7'h4F, 7'h3F, 7'h07}, 4'b0100};
      tbl[5] = '{10, 59,  1, 1, {7'h06, 7'h3F, 7'h6D, 7'h6F}, 4'b0001};
      tbl[6] = '{13,  0,  0, 0, DASHES,                       4'b0000};
      tbl[7] = '{12, 30,  2, 0, {7'h06, 7'h5B, 7'h4F, 7'h3F}, 4'b0100};

      bus.ena = 1'b1;
      set_time(12, 0, 0, 0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_seg", 32'(bus.seg), 32'h0);
      chk("reset_dp", 32'(bus.dp), 32'h0);
      chk("reset_dig_en", 32'(bus.dig_en), 32'h0);
      rst_n = 1'b1;

      capture(0, segs, dps);
      chk("first_frame_seg", 32'(segs), 32'(tbl[0].segs));
      chk("first_frame_dp", 32'(dps), 32'(tbl[0].dps));

      for (int i = 1; i < 8; i++) begin
         set_time(tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].ap);
         capture(1, segs, dps);
         chk($sformatf("tbl%0d_seg", i), 32'(segs), 32'(tbl[i].segs));
         chk($sformatf("tbl%0d_dp", i), 32'(dps), 32'(tbl[i].dps));
      end

      // Minute change in slot 2 must not tear the frame in progress
      set_time(9, 45, 7, 1);
      capture(1, segs, dps);
      wait_dig(4'b0001, "tear_slot0");
      chk("tear_old_dig0", 32'(bus.seg), 32'h6D);
      wait_dig(4'b0100, "tear_slot2");
      bus.minutes = 6'd46;
      wait_dig(4'b1000, "tear_slot3");
      chk("tear_cur_dig3", 32'(bus.seg), 32'(HT0));
      wait_dig(4'b0001, "tear_next");
      chk("tear_new_dig0", 32'(bus.seg), 32'h7D);

      // Freeze at slot 1, cnt 4
      wait_dig(4'b0010, "ena_slot1");
      @(negedge clk);
      bus.ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("ena_off_%0d", i), {bus.seg, bus.dp, bus.dig_en}, 32'h0);
      end
      bus.ena = 1'b1;
      @(negedge clk);
      chk("resume_seg", 32'(bus.seg), 32'h66);
      n = 0;
      while (bus.dig_en == 4'b0010 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("resume_dig1_cycles", 32'(n), 32'd4);
      n = 0;
      while (bus.dig_en == 4'b0000 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("resume_blank_gap", 32'(n), 32'd2);
      chk("resume_next_slot", 32'(bus.dig_en), 32'b0100);

      // Three frames of free running
      for (int k = 0; k < 4; k++) cnt_on[k] = 0;
      multi = 0;
      for (int c = 0; c < 96; c++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (bus.dig_en[k]) cnt_on[k]++;
         if (!$onehot0(bus.dig_en)) multi++;
      end
      for (int k = 0; k < 4; k++) chk($sformatf("free_dig%0d_on", k), 32'(cnt_on[k]), 32'd18);
      chk("free_onehot", 32'(multi), 32'd0);

      // Mid-slot asynchronous reset, then the reset snapshot must show
      set_time(10, 59, 1, 1);
      capture(1, segs, dps);
      wait_dig(4'b0100, "rst_mid");
      #2 rst_n = 1'b0;
      #1 chk("async_rst_out", {bus.seg, bus.dp, bus.dig_en}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      capture(0, segs, dps);
      chk("rst_snapshot_seg", 32'(segs), 32'(tbl[0].segs));
      chk("rst_snapshot_dp", 32'(dps), 32'(tbl[0].dps));

      for (int i = 0; i < 12; i++) begin
         int h, m, s, ap;
         h  = ($urandom % 6 == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
         m  = ($urandom % 6 == 0) ? $urandom_range(0, 63) : $urandom_range(0, 59);
         s  = $urandom_range(0, 63);
         ap = $urandom_range(0, 1);
         set_time(h, m, s, ap);
         model(h, m, s, ap, esegs, edps);
         capture(1, segs, dps);
         chk($sformatf("rand%0d_seg_%0d:%0d", i, h, m), 32'(segs), 32'(esegs));
         chk($sformatf("rand%0d_dp", i), 32'(dps), 32'(edps));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
